izh_neuron_scheduler: RTL

IZH_NEURON_SCHEDULER -- requirements
Module: izh_neuron_scheduler

---
 rtl/izh_pkg.sv | 43 ++++
 rtl/izh_update_unit.sv | 37 +++
 rtl/izh_neuron_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/izh_pkg.sv
// Shared types, FSM encoding, config select codes and default neuron constants
// for the Izhikevich neuron scheduler.
package izh_pkg;

    localparam int unsigned N_DEF = 18;
    localparam int unsigned Q_DEF = 10;

    typedef logic signed [N_DEF-1:0] fix_t;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StCalc  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CfgA     = 3'd0,
        CfgB     = 3'd1,
        CfgC     = 3'd2,
        CfgD     = 3'd3,
        CfgVth   = 3'd4,
        CfgVinit = 3'd5,
        CfgWinit = 3'd6
    } cfg_sel_e;

    // Defaults in hundredths of the scaled units; converted to Q format where used.
    localparam int A_HUND   = 2;
    localparam int B_HUND   = 20;
    localparam int C_HUND   = -65;
    localparam int D_HUND   = 8;
    localparam int VTH_HUND = 30;
    localparam int K_HUND   = 140;

    // Round-half-away-from-zero conversion of num/den to q fractional bits.
    function automatic int fx_round(input int num, input int den, input int unsigned q);
        int mag;
        mag = (((num < 0) ? -num : num) * (1 << q) + den / 2) / den;
        return (num < 0) ? -mag : mag;
    endfunction

endpackage

// File: rtl/izh_update_unit.sv
// Combinational Izhikevich update datapath: dv = (4v^2 + 5v + 1.4 - w + i) * step,
// dw = a * (b*v - w) * step. Products truncate to Q fractional bits, sums wrap.
module izh_update_unit #(
    parameter int unsigned N = 18,
    parameter int unsigned Q = 10
) (
    input  logic signed [N-1:0] v,
    input  logic signed [N-1:0] w,
    input  logic signed [N-1:0] i_cur,
    input  logic signed [N-1:0] step,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] k140,
    output logic signed [N-1:0] dv,
    output logic signed [N-1:0] dw
);

    function automatic logic signed [N-1:0] fmul(input logic signed [N-1:0] x,
                                                 input logic signed [N-1:0] y);
        logic signed [2*N-1:0] p;
        p = x * y;
        return N'(p >>> Q);
    endfunction

    logic signed [N-1:0] v_sq;
    logic signed [N-1:0] dv_sum;
    logic signed [N-1:0] bv_w;

    always_comb begin
        v_sq   = fmul(v, v);
        dv_sum = (v_sq <<< 2) + (v <<< 2) + v + k140 - w + i_cur;
        dv     = fmul(dv_sum, step);
        bv_w   = fmul(b, v) - w;
        dw     = fmul(fmul(a, bv_w), step);
    end

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Sweeps NUM_NEURONS Izhikevich neurons through one shared update unit per start pulse.
// Optional feature macro IZH_SPIKE_COUNT_EN adds a saturating 16-bit spike_count output.
module izh_neuron_scheduler
    import izh_pkg::*;
#(
    parameter int unsigned N           = N_DEF,
    parameter int unsigned Q           = Q_DEF,
    parameter int unsigned NUM_NEURONS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic signed [N-1:0]            step,
    output logic                           i_req,
    output logic [$clog2(NUM_NEURONS)-1:0] i_idx,
    input  logic signed [N-1:0]            i_data,
    input  logic                           i_valid,
    output logic                           spike_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] spike_idx,
    output logic                           busy,
    output logic                           done,
`ifdef IZH_SPIKE_COUNT_EN
    output logic [15:0]                    spike_count,
`endif
    input  logic                           cfg_we,
    input  logic [2:0]                     cfg_sel,
    input  logic signed [N-1:0]            cfg_data
);

    localparam int unsigned IW = $clog2(NUM_NEURONS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
    localparam int B_INT = fx_round(B_HUND, 100, Q);
    localparam int C_INT = fx_round(C_HUND, 100, Q);
    localparam logic signed [N-1:0] A_RST   = N'(fx_round(A_HUND, 100, Q));
    localparam logic signed [N-1:0] B_RST   = N'(B_INT);
    localparam logic signed [N-1:0] C_RST   = N'(C_INT);
    localparam logic signed [N-1:0] D_RST   = N'(fx_round(D_HUND, 100, Q));
    localparam logic signed [N-1:0] VTH_RST = N'(fx_round(VTH_HUND, 100, Q));
    localparam logic signed [N-1:0] K140    = N'(fx_round(K_HUND, 100, Q));
    localparam logic signed [N-1:0] W_RST   = N'((B_INT * C_INT) >>> Q);

    state_e state_q, state_d;
    logic [IW-1:0] idx_q;
    logic signed [N-1:0] step_q, icur_q, dv_q, dw_q;
    logic signed [N-1:0] a_q, b_q, c_q, d_q, vth_q;
    logic signed [N-1:0] v_mem [NUM_NEURONS];
    logic signed [N-1:0] w_mem [NUM_NEURONS];
    logic signed [N-1:0] v_cur, w_cur, v_next, d_add, dv, dw;
    logic fire;

    assign v_cur  = v_mem[idx_q];
    assign w_cur  = w_mem[idx_q];
    assign v_next = v_cur + dv_q;
    assign fire   = (v_next >= vth_q);
    assign d_add  = fire ? d_q : N'(0);

    izh_update_unit #(
        .N (N),
        .Q (Q)
    ) u_update (
        .v     (v_cur),
        .w     (w_cur),
        .i_cur (icur_q),
        .step  (step_q),
        .a     (a_q),
        .b     (b_q),
        .k140  (K140),
        .dv    (dv),
        .dw    (dw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (i_valid) state_d = StCalc;
            StCalc:  state_d = StWrite;
            StWrite: state_d = (idx_q == LAST_IDX) ? StDone : StFetch;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = 1'b1;
        i_req       = 1'b0;
        done        = 1'b0;
        spike_valid = 1'b0;
        case (state_q)
            StIdle:  busy = 1'b0;
            StFetch: i_req = 1'b1;
            StWrite: spike_valid = fire;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign i_idx     = idx_q;
    assign spike_idx = idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            step_q <= '0;
            icur_q <= '0;
            dv_q   <= '0;
            dw_q   <= '0;
            a_q    <= A_RST;
            b_q    <= B_RST;
            c_q    <= C_RST;
            d_q    <= D_RST;
            vth_q  <= VTH_RST;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k] <= C_RST;
                w_mem[k] <= W_RST;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) step_q <= step;
                    if (cfg_we) begin
                        case (cfg_sel)
                            CfgA:     a_q   <= cfg_data;
                            CfgB:     b_q   <= cfg_data;
                            CfgC:     c_q   <= cfg_data;
                            CfgD:     d_q   <= cfg_data;
                            CfgVth:   vth_q <= cfg_data;
                            CfgVinit: for (int k = 0; k < NUM_NEURONS; k++) v_mem[k] <= cfg_data;
                            CfgWinit: for (int k = 0; k < NUM_NEURONS; k++) w_mem[k] <= cfg_data;
                            default: ;
                        endcase
                    end
                end
                StFetch: if (i_valid) icur_q <= i_data;
                StCalc: begin
                    dv_q <= dv;
                    dw_q <= dw;
                end
                StWrite: begin
                    v_mem[idx_q] <= fire ? c_q : v_next;
                    w_mem[idx_q] <= w_cur + dw_q + d_add;
                    if (idx_q != LAST_IDX) idx_q <= idx_q + IW'(1);
                end
                StDone: idx_q <= '0;
                default: ;
            endcase
        end
    end

`ifdef IZH_SPIKE_COUNT_EN
    logic [15:0] spk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_cnt_q <= '0;
        end else if (state_q == StIdle && start) begin
            spk_cnt_q <= '0;
        end else if (spike_valid && spk_cnt_q != 16'hFFFF) begin
            spk_cnt_q <= spk_cnt_q + 16'd1;
        end
    end

    assign spike_count = spk_cnt_q;
`endif

endmodule
